// File: rtl/accum_update.sv
// accum_update: read-modify-write front end for the word-count accumulator array.
// Accepts (index, increment) pairs and performs a saturating add into the
// addressed entry through the array's single shared addr/din/we port, backing
// off (and replaying from the read) whenever the array runs its clear sequence.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid/in_ready      update request handshake
//   in_addr, in_incr       accumulator index, unsigned increment
//   clear_busy             array clear in progress (array owns its port)
//   addr, din, we          array port (combinational from state/holding regs/q)
//   q                      array read data, valid the cycle after a read
//   idle                   no update held or in flight
//   update_count           completed writes (wraps)
//   sat_count              saturated writes (wraps)
module accum_update #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned INCR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [INCR_WIDTH-1:0] in_incr,
    input  logic                  clear_busy,
    output logic [31:0]           addr,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  we,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  idle,
    output logic [31:0]           update_count,
    output logic [31:0]           sat_count
);

    localparam int unsigned SUM_W = DATA_WIDTH + 1;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [ADDR_WIDTH-1:0]   h_addr;
    logic [INCR_WIDTH-1:0]   h_incr;
    logic [SUM_W-1:0]        sum;
    logic                    sat;
    logic                    accept;

    // Saturating add: the extra top bit is the carry-out.
    assign sum    = {1'b0, q} + SUM_W'(h_incr);
    assign sat    = sum[DATA_WIDTH];
    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; a clear during RD or WR sends the op back to RD.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_RD;
                end
            end
            S_RD: begin
                if (!clear_busy) begin
                    state_n = S_WR;
                end
            end
            S_WR: begin
                if (clear_busy) begin
                    state_n = S_RD;
                end else if (accept) begin
                    state_n = S_RD;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Output logic: array port and handshake are combinational from state.
    always_comb begin
        in_ready = 1'b0;
        addr     = '0;
        din      = '0;
        we       = 1'b0;
        idle     = 1'b0;
        case (state)
            S_IDLE: begin
                idle     = 1'b1;
                in_ready = !clear_busy;
            end
            S_RD: begin
                addr = 32'(h_addr);
            end
            S_WR: begin
                addr     = 32'(h_addr);
                din      = sat ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
                we       = !clear_busy;
                in_ready = !clear_busy;
            end
            default: begin
                idle = 1'b0;
            end
        endcase
    end

    // Holding registers capture the request on the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_addr <= '0;
            h_incr <= '0;
        end else if (accept) begin
            h_addr <= in_addr;
            h_incr <= in_incr;
        end
    end

    // Write and saturation counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            update_count <= '0;
            sat_count    <= '0;
        end else if (we) begin
            update_count <= update_count + CNT_W'(1);
            if (sat) begin
                sat_count <= sat_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_accum_update.sv
// Directed bench for accum_update with a behavioural accumulator array model
// and an independent reference array for the random soak.
module tb_accum_update;

    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 64;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned NSOAK = 10000;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [IW-1:0] in_incr;
    logic          clear_busy;
    logic [31:0]   addr;
    logic [DW-1:0] din;
    logic          we;
    logic [DW-1:0] q;
    logic          idle;
    logic [31:0]   update_count;
    logic [31:0]   sat_count;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          bd_en;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    accum_update #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INCR_WIDTH(IW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_incr      (in_incr),
        .clear_busy   (clear_busy),
        .addr         (addr),
        .din          (din),
        .we           (we),
        .q            (q),
        .idle         (idle),
        .update_count (update_count),
        .sat_count    (sat_count)
    );

    // Accumulator array: clear zeroes every entry while busy; otherwise
    // backdoor load, write, or registered read.
    always @(posedge clk) begin
        if (clear_busy) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (bd_en) begin
            mem[bd_addr] <= bd_data;
        end else if (we) begin
            mem[addr[AW-1:0]] <= din;
        end else begin
            q <= mem[addr[AW-1:0]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_en = 1'b0;
        #1;
    endtask

    // Send one request, wait for its write, and check the written word.
    task automatic send_one(input logic [AW-1:0] a, input logic [IW-1:0] inc,
                            input logic [DW-1:0] exp_din);
        int n;
        in_valid = 1'b1; in_addr = a; in_incr = inc;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        check("send_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        n = 0;
        while (!we && n < 10) begin tick(); n++; end
        check("send_we", 64'(we), 64'd1);
        check("send_addr", 64'(addr), 64'(a));
        check("send_din", din, exp_din);
        tick();
    endtask

    initial begin
        int acc;
        int bad;
        int n;
        int gap;
        logic [AW-1:0] ra;
        logic [IW-1:0] ri;
        logic [DW:0]   rs;
        int unsigned   ref_sat;

        reset = 1'b1; clear_busy = 1'b1; in_valid = 1'b0;
        in_addr = '0; in_incr = '0; bd_en = 1'b0; bd_addr = '0; bd_data = '0;
        tick(); tick();
        clear_busy = 1'b0;
        tick();
        // reset values
        check("rst_we", 64'(we), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_din", din, 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_upd", 64'(update_count), 64'd0);
        check("rst_sat", 64'(sat_count), 64'd0);
        reset = 1'b0;
        tick();
        check("rst_ready", 64'(in_ready), 64'd1);

        // single update (5,3): RD then WR, write two edges after accept
        in_valid = 1'b1; in_addr = 14'd5; in_incr = 32'd3;
        #1;
        check("s_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("s_rd_we", 64'(we), 64'd0);
        check("s_rd_addr", 64'(addr), 64'd5);
        check("s_rd_ready", 64'(in_ready), 64'd0);
        tick();
        check("s_wr_we", 64'(we), 64'd1);
        check("s_wr_addr", 64'(addr), 64'd5);
        check("s_wr_din", din, 64'd3);
        tick();
        check("s_idle", 64'(idle), 64'd1);
        check("s_upd", 64'(update_count), 64'd1);
        check("s_mem", mem[5], 64'd3);

        // back-to-back (7,1) x4: writes at every second edge, ready alternates
        acc = 0;
        in_valid = 1'b1; in_addr = 14'd7; in_incr = 32'd1;
        #1;
        for (int i = 0; i < 9; i++) begin
            check("b2b_ready", 64'(in_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            if (i % 2 == 0 && i > 0) begin
                check("b2b_we", 64'(we), 64'd1);
                check("b2b_din", din, 64'(i / 2));
            end else begin
                check("b2b_we", 64'(we), 64'd0);
            end
            if (in_valid && in_ready) acc++;
            tick();
            if (acc == 4) in_valid = 1'b0;
            #1;
        end
        check("b2b_idle", 64'(idle), 64'd1);
        check("b2b_upd", 64'(update_count), 64'd5);
        check("b2b_mem", mem[7], 64'd4);

        // saturation on entry 9
        backdoor(14'd9, 64'hFFFF_FFFF_FFFF_FFFE);
        send_one(14'd9, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sat_cnt1", 64'(sat_count), 64'd1);
        send_one(14'd9, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sat_cnt2", 64'(sat_count), 64'd2);
        check("sat_upd", 64'(update_count), 64'd7);

        // clear during the WR of (4,10) on an entry holding 6
        backdoor(14'd4, 64'd6);
        in_valid = 1'b1; in_addr = 14'd4; in_incr = 32'd10;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        tick();
        check("clr_pre_we", 64'(we), 64'd1);
        check("clr_pre_din", din, 64'd16);
        clear_busy = 1'b1;
        #1;
        check("clr_we0", 64'(we), 64'd0);
        check("clr_ready0", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_we", 64'(we), 64'd0);
            check("clr_ready", 64'(in_ready), 64'd0);
            check("clr_idle", 64'(idle), 64'd0);
        end
        clear_busy = 1'b0;
        #1;
        check("clr_rd_we", 64'(we), 64'd0);
        check("clr_rd_addr", 64'(addr), 64'd4);
        tick();
        check("clr_wr_we", 64'(we), 64'd1);
        check("clr_wr_din", din, 64'd10);
        tick();
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++)
            if (i != 4 && mem[i] != '0) bad++;
        check("clr_others_zero", 64'(bad), 64'd0);
        check("clr_mem4", mem[4], 64'd10);
        check("clr_upd", 64'(update_count), 64'd8);

        // reset during the RD of (2,7)
        in_valid = 1'b1; in_addr = 14'd2; in_incr = 32'd7;
        #1;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        tick();
        check("mrst_we", 64'(we), 64'd0);
        check("mrst_addr", 64'(addr), 64'd0);
        check("mrst_din", din, 64'd0);
        check("mrst_idle", 64'(idle), 64'd1);
        check("mrst_upd", 64'(update_count), 64'd0);
        check("mrst_sat", 64'(sat_count), 64'd0);
        reset = 1'b0;
        #1;
        tick();
        check("mrst_ready", 64'(in_ready), 64'd1);
        check("mrst_mem2", mem[2], 64'd0);
        send_one(14'd2, 32'd1, 64'd1);
        check("mrst_upd1", 64'(update_count), 64'd1);

        // random soak against a reference array
        reset = 1'b1; clear_busy = 1'b1;
        tick();
        reset = 1'b0; clear_busy = 1'b0;
        #1;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        ref_sat = 0;
        for (int k = 0; k < int'(NSOAK); k++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            ra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31))
                                             : AW'($urandom_range(0, DEPTH - 1));
            ri = $urandom();
            in_valid = 1'b1; in_addr = ra; in_incr = ri;
            #1;
            n = 0;
            while (!in_ready && n < 20) begin tick(); n++; end
            if (n >= 20) begin
                check("soak_ready", 64'(in_ready), 64'd1);
                break;
            end
            rs = {1'b0, ref_mem[ra]} + (DW + 1)'(ri);
            if (rs[DW]) begin
                ref_mem[ra] = '1;
                ref_sat++;
            end else begin
                ref_mem[ra] = rs[DW-1:0];
            end
            tick();
            in_valid = 1'b0;
            #1;
        end
        n = 0;
        while (!idle && n < 20) begin tick(); n++; end
        check("soak_idle", 64'(idle), 64'd1);
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++)
            if (mem[i] !== ref_mem[i]) bad++;
        check("soak_mem", 64'(bad), 64'd0);
        check("soak_upd", 64'(update_count), 64'(NSOAK));
        check("soak_sat", 64'(sat_count), 64'(ref_sat));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
